rv32i_uart_tx: RTL and testbench
================================

# rv32i_uart_tx

Memory-mapped UART transmitter that acts as a responder on the rv32i core data bus. It is wired to the core's data memory port alongside data RAM. Store instructions fill a small TX FIFO, and a serializer drives 8N1 frames on `tx_o`. Reads return status combinationally in the same cycle, which matches the single-cycle core's load timing.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h80000000: 16-byte aligned base of the register window.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of 2, at least 2.
- `DEFAULT_DIV`, default 16'd433: reset value of BAUDDIV.

Ports:
- `clk_i` input 1: single clock, all state on the rising edge.
- `rst_in` input 1: reset, asynchronous and active-low.
- `mem_addr_i` input 32: byte address from the core.
- `mem_din_i` input 32: write data from the core.
- `mem_we_i` input 1: write strobe, one cycle per store.
- `mem_be_i` input 4: byte enables.
- `mem_dout_o` output 32: read data; combinational from the address and registered state.
- `tx_o` output 1: serial line, idle high.

## Operation
- The block is hit when `mem_addr_i[31:4] == BASE_ADDR[31:4]`. The register is selected by `mem_addr_i[3:2]`. Address bits [1:0] are ignored.
- When not hit: `mem_dout_o` = 0 and writes have no effect.
- Offset 0x0, TXDATA (write-only, reads 0):
  - A write with `mem_be_i[0]=1` pushes `mem_din_i[7:0]`.
  - If the FIFO is full, the byte is dropped and OVF is set.
  - A full FIFO drops the push even if a pop happens in the same cycle.
- Offset 0x4, STATUS (read):
  - bit0 BUSY = serializer not idle OR FIFO non-empty.
  - bit1 FULL; bit2 EMPTY; bit3 OVF (sticky).
  - bits [3+L:4] LEVEL, where L = log2(FIFO_DEPTH)+1. For depth 4, LEVEL is 0..4 in bits [6:4].
  - All other bits read 0.
  - Writing 1 to bit3 with `be[0]` clears OVF. If an overflow occurs in the same cycle, the set wins.
- Offset 0x8, BAUDDIV (r/w):
  - bits [15:0] DIV; bits [31:16] read 0.
  - Byte lanes 0 and 1 are written independently per `be[0]` and `be[1]`.
  - The bit period is DIV+1 clocks; DIV=0 gives 1 clock per bit.
  - A new DIV takes effect at the next bit-counter reload; the current bit finishes with the old count.
- Offset 0xC: reserved; reads 0, writes ignored.
- Serializer FSM, with states IDLE, START, DATA, STOP:
  - IDLE → START when the FIFO is non-empty. The head is popped into the shift register on that edge.
  - START holds `tx_o`=0 for DIV+1 clocks.
  - DATA sends 8 bits LSB first, each DIV+1 clocks. A 3-bit index counts 0..7.
  - STOP holds `tx_o`=1 for DIV+1 clocks.
  - At the end of STOP: if the FIFO is non-empty, go directly to START and pop the next byte (back-to-back frames, no idle gap); otherwise go to IDLE.
- The FIFO is a circular buffer. Read and write pointers wrap modulo FIFO_DEPTH. The level counter is 0..FIFO_DEPTH.
- A push into an empty FIFO and a pop from the FIFO in the same cycle cannot both occur: a pop requires non-empty as registered at the edge.
- `tx_o` is registered, driven from the FSM and shift-register state, with no combinational path from the bus.

## Timing
- Reset values:
  - `tx_o`=1; FSM=IDLE; FIFO empty with pointers 0; OVF=0; DIV=DEFAULT_DIV; bit counter 0.
  - `mem_dout_o` reflects the reset state: STATUS reads 0x4.
- Reset asserted mid-frame: `tx_o` goes high immediately (asynchronous). The FIFO contents and the partial frame are discarded.
- TXDATA write at edge N:
  - LEVEL increments after edge N.
  - At edge N+1 the FSM enters START and pops; `tx_o` falls after edge N+1.
- A frame lasts exactly 10·(DIV+1) clocks from the falling start edge to the end of the stop bit.
- Read latency is 0: `mem_dout_o` is valid in the same cycle the address is presented and reflects state after the last edge.
- BUSY falls on the edge that ends the final STOP bit with the FIFO empty.

## Test plan
- Reset: hold `rst_in`=0, then release. Required: `tx_o`=1, STATUS=0x4, BAUDDIV reads DEFAULT_DIV, reads outside the window return 0.
- Single frame: write DIV=3, then TXDATA=0xA5. Required: `tx_o` low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks. BUSY=1 throughout and clears at frame end.
- Overflow: DIV=0; 5 TXDATA writes on consecutive cycles while the line is idle (first byte popped at N+1). Required: with depth 4, the 6th write before any further pop sets OVF and FULL. All accepted bytes are then sent back-to-back in order with no idle gap. OVF stays set until STATUS is written with 0x8.
- Byte enables: write BAUDDIV 0x1234 with be=0b0010. Required: DIV=0x12xx, where the low byte keeps its previous value. A TXDATA write with be=0b1110 pushes nothing.
- Mid-frame DIV change: while in DATA with DIV=7, write DIV=1. Required: the current bit lasts 8 clocks, following bits last 2 clocks.
- Reset mid-frame: assert `rst_in` during DATA with 2 bytes queued. Required: `tx_o`=1 asynchronously, LEVEL=0 after release, no further frames.

Source files
------------

// File: rtl/rv32i_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the rv32i data bus.
// Stores fill a small TX FIFO; a registered serializer drives tx_o.
module rv32i_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_din_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  output logic [31:0] mem_dout_o,
  output logic        tx_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t         state, state_d;
  logic [15:0]    div, cnt, cnt_d;
  logic [2:0]     idx, idx_d;
  logic [7:0]     sh, sh_d;
  logic           tx_d;
  logic           pop;

  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [LW-1:0]  level;
  logic           ovf;

  logic           hit, full, empty, busy;
  logic           push_req, push, ovf_clr;
  logic [31:0]    status;
  logic           unused_bits;

  assign unused_bits = ^mem_din_i[31:16];

  assign hit      = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign full     = (level == LW'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign busy     = (state != S_IDLE) || !empty;
  assign push_req = hit && mem_we_i && (mem_addr_i[3:2] == 2'd0) && mem_be_i[0];
  assign push     = push_req && !full;
  assign ovf_clr  = hit && mem_we_i && (mem_addr_i[3:2] == 2'd1) && mem_be_i[0] && mem_din_i[3];

  // FIFO storage has no reset; the pointers and level define validity.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr] <= mem_din_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
      div   <= DEFAULT_DIV;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // An overflow in the same cycle as a clear leaves OVF set.
      if (push_req && full) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
      if (hit && mem_we_i && (mem_addr_i[3:2] == 2'd2)) begin
        if (mem_be_i[0]) div[7:0]  <= mem_din_i[7:0];
        if (mem_be_i[1]) div[15:8] <= mem_din_i[15:8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx_o  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      sh    <= sh_d;
      tx_o  <= tx_d;
    end
  end

  // The bit counter reloads from div only at bit boundaries, so a DIV
  // write never stretches or truncates the bit in flight.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    tx_d    = tx_o;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_START;
          pop     = 1'b1;
          sh_d    = fifo_mem[rptr];
          cnt_d   = div;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          state_d = S_DATA;
          cnt_d   = div;
          idx_d   = '0;
          tx_d    = sh[0];
          sh_d    = {1'b0, sh[7:1]};
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          cnt_d = div;
          if (idx == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx + 1'b1;
            tx_d  = sh[0];
            sh_d  = {1'b0, sh[7:1]};
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == '0) begin
          if (!empty) begin
            state_d = S_START;
            pop     = 1'b1;
            sh_d    = fifo_mem[rptr];
            cnt_d   = div;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status            = '0;
    status[0]         = busy;
    status[1]         = full;
    status[2]         = empty;
    status[3]         = ovf;
    status[4 +: LW]   = level;
    mem_dout_o        = '0;
    if (hit) begin
      case (mem_addr_i[3:2])
        2'd1:    mem_dout_o = status;
        2'd2:    mem_dout_o = {16'h0000, div};
        default: mem_dout_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_uart_tx.sv
// Directed bench for rv32i_uart_tx: register table plus serial-line sequences.
module tb_rv32i_uart_tx;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] A_TX   = BASE + 32'h0;
  localparam logic [31:0] A_ST   = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_din_i;
  logic        mem_we_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_dout_o;
  logic        tx_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        expq[$];

  rv32i_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .mem_addr_i(mem_addr_i),
    .mem_din_i (mem_din_i),
    .mem_we_i  (mem_we_i),
    .mem_be_i  (mem_be_i),
    .mem_dout_o(mem_dout_o),
    .tx_o      (tx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk_i);
    mem_addr_i = a;
    mem_be_i   = be;
    mem_din_i  = d;
    mem_we_i   = 1'b1;
    @(posedge clk_i);
    #1;
    mem_we_i = 1'b0;
    mem_be_i = 4'h0;
  endtask

  task automatic check_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(negedge clk_i);
    mem_addr_i = a;
    mem_we_i   = 1'b0;
    #1;
    check(name, mem_dout_o, exp);
  endtask

  task automatic add_bits(input logic v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) expq.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int unsigned per);
    add_bits(1'b0, per);
    for (int unsigned i = 0; i < 8; i++) add_bits(b[i], per);
    add_bits(1'b1, per);
  endtask

  // Samples tx_o on n consecutive falling edges against expq (idle-high past its end).
  task automatic watch(input int unsigned n, input string name);
    logic e;
    for (int unsigned j = 0; j < n; j++) begin
      @(negedge clk_i);
      e = (j < expq.size()) ? expq[j] : 1'b1;
      check($sformatf("%s_tx[%0d]", name, j), {31'b0, tx_o}, {31'b0, e});
    end
  endtask

  initial begin
    rst_in     = 1'b0;
    mem_addr_i = '0;
    mem_din_i  = '0;
    mem_we_i   = 1'b0;
    mem_be_i   = 4'h0;

    vecs[0]  = '{A_ST,            1'b0, 4'h0, 32'h0,         32'h0000_0004};
    vecs[1]  = '{A_DIV,           1'b0, 4'h0, 32'h0,         32'h0000_01B1};
    vecs[2]  = '{A_TX,            1'b0, 4'h0, 32'h0,         32'h0};
    vecs[3]  = '{A_RSV,           1'b0, 4'h0, 32'h0,         32'h0};
    vecs[4]  = '{32'h8000_0014,   1'b0, 4'h0, 32'h0,         32'h0};
    vecs[5]  = '{32'h0000_0004,   1'b0, 4'h0, 32'h0,         32'h0};
    vecs[6]  = '{BASE + 32'h6,    1'b0, 4'h0, 32'h0,         32'h0000_0004};
    vecs[7]  = '{A_DIV,           1'b1, 4'h2, 32'h0000_1234, 32'h0};
    vecs[8]  = '{A_DIV,           1'b0, 4'h0, 32'h0,         32'h0000_12B1};
    vecs[9]  = '{A_DIV,           1'b1, 4'h1, 32'hFFFF_FF03, 32'h0};
    vecs[10] = '{A_DIV,           1'b0, 4'h0, 32'h0,         32'h0000_1203};
    vecs[11] = '{A_DIV,           1'b1, 4'h3, 32'hABCD_0003, 32'h0};
    vecs[12] = '{A_DIV,           1'b0, 4'h0, 32'h0,         32'h0000_0003};
    vecs[13] = '{32'h9000_0008,   1'b1, 4'hF, 32'h0000_0007, 32'h0};
    vecs[14] = '{A_DIV,           1'b0, 4'h0, 32'h0,         32'h0000_0003};
    vecs[15] = '{A_TX,            1'b1, 4'hE, 32'h0000_0055, 32'h0};
    vecs[16] = '{A_ST,            1'b0, 4'h0, 32'h0,         32'h0000_0004};
    vecs[17] = '{A_RSV,           1'b1, 4'hF, 32'h0000_00FF, 32'h0};
    vecs[18] = '{A_ST,            1'b0, 4'h0, 32'h0,         32'h0000_0004};

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_tx", {31'b0, tx_o}, 32'h1);
    @(negedge clk_i);
    rst_in = 1'b1;

    for (int unsigned i = 0; i < 19; i++) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].be, vecs[i].din);
      else            check_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    check("idle_tx", {31'b0, tx_o}, 32'h1);

    // Single frame, DIV=3 (4 clocks per bit).
    expq.delete();
    add_bits(1'b1, 2);
    add_frame(8'hA5, 4);
    fork
      watch(46, "frame");
      begin
        do_write(A_TX, 4'h1, 32'h0000_00A5);
        for (int unsigned j = 0; j <= 41; j++) begin
          @(negedge clk_i);
          mem_addr_i = A_ST;
          #1;
          if (j == 0)       check("frame_st_push", mem_dout_o, 32'h0000_0011);
          else if (j < 41)  check($sformatf("frame_busy[%0d]", j), {31'b0, mem_dout_o[0]}, 32'h1);
          else              check("frame_st_end", mem_dout_o, 32'h0000_0004);
        end
      end
    join

    // Overflow with DIV=0: six back-to-back pushes, sixth dropped.
    do_write(A_DIV, 4'h3, 32'h0);
    expq.delete();
    add_bits(1'b1, 2);
    add_frame(8'h01, 1);
    add_frame(8'h80, 1);
    add_frame(8'hC3, 1);
    add_frame(8'h5A, 1);
    add_frame(8'hFF, 1);
    fork
      watch(58, "ovf");
      begin
        do_write(A_TX, 4'h1, 32'h01);
        do_write(A_TX, 4'h1, 32'h80);
        do_write(A_TX, 4'h1, 32'hC3);
        do_write(A_TX, 4'h1, 32'h5A);
        do_write(A_TX, 4'h1, 32'hFF);
        do_write(A_TX, 4'h1, 32'h77);
        check_read(A_ST, 32'h0000_004B, "ovf_full_st");
        check_read(A_ST, 32'h0000_004B, "ovf_full_st2");
      end
    join
    check_read(A_ST, 32'h0000_000C, "ovf_sticky");
    do_write(A_ST, 4'h2, 32'h0000_0008);
    check_read(A_ST, 32'h0000_000C, "ovf_clr_wrong_lane");
    do_write(A_ST, 4'h1, 32'h0000_0008);
    check_read(A_ST, 32'h0000_0004, "ovf_cleared");

    // DIV 7 -> 1 while bit 0 of DATA is on the line.
    do_write(A_DIV, 4'h3, 32'h7);
    expq.delete();
    add_bits(1'b1, 2);
    add_bits(1'b0, 8);
    add_bits(1'b0, 8);
    add_bits(1'b0, 2);
    add_bits(1'b1, 2);
    add_bits(1'b1, 2);
    add_bits(1'b1, 2);
    add_bits(1'b1, 2);
    add_bits(1'b0, 2);
    add_bits(1'b0, 2);
    add_bits(1'b1, 2);
    fork
      watch(40, "divchg");
      begin
        do_write(A_TX, 4'h1, 32'h3C);
        repeat (10) @(posedge clk_i);
        do_write(A_DIV, 4'h3, 32'h1);
      end
    join
    check_read(A_DIV, 32'h0000_0001, "divchg_rd");
    check_read(A_ST, 32'h0000_0004, "divchg_idle");

    // Asynchronous reset in the middle of a frame with two bytes queued.
    do_write(A_DIV, 4'h3, 32'h3);
    do_write(A_TX, 4'h1, 32'h00);
    do_write(A_TX, 4'h1, 32'h11);
    do_write(A_TX, 4'h1, 32'h22);
    check_read(A_ST, 32'h0000_0021, "rst_pre_level");
    repeat (3) @(posedge clk_i);
    #2;
    check("rst_pre_line", {31'b0, tx_o}, 32'h0);
    mem_addr_i = A_ST;
    rst_in = 1'b0;
    #1;
    check("rst_async_tx", {31'b0, tx_o}, 32'h1);
    check("rst_async_st", mem_dout_o, 32'h0000_0004);
    repeat (2) @(negedge clk_i);
    rst_in = 1'b1;
    check_read(A_ST, 32'h0000_0004, "rst_post_st");
    check_read(A_DIV, 32'h0000_01B1, "rst_post_div");
    expq.delete();
    watch(60, "rst_quiet");
    check_read(A_ST, 32'h0000_0004, "rst_final_st");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
